// File: rtl/router_egress_checker.sv
// Drains one router output port, re-frames bytes into packets and checks address and parity.
// Optional ERR_CNT_EN adds a saturating 8-bit err_count output.
module router_egress_checker #(
    parameter logic [1:0]  DEST_ADDR = 2'd0,
    parameter int unsigned TIMEOUT   = 30,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             valid_out,
    input  logic [7:0]       data_out,
    output logic             read_enb,
    input  logic             sink_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_sof,
    output logic             out_eof,
    output logic             pkt_done,
    output logic             parity_err,
    output logic             addr_err,
    output logic             timeout_err,
    output logic [CNT_W-1:0] pkt_count
`ifdef ERR_CNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    typedef enum logic [1:0] {StHdr, StPay, StPar} state_e;

    localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             rd_q, rd_d;
    logic [5:0]       len_q, len_d;
    logic [7:0]       par_q, par_d;
    logic [7:0]       tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ov_q, ov_d;
    logic [7:0]       od_q, od_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             perr_q, perr_d;
    logic             aerr_q, aerr_d;
    logic             terr_q, terr_d;

    // resetn gates the request so no read is issued while the block is held in reset
    assign read_enb = valid_out & sink_ready & resetn;

    always_comb begin
        state_d = state_q;
        rd_d    = read_enb;
        len_d   = len_q;
        par_d   = par_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        ov_d    = 1'b0;
        od_d    = od_q;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        perr_d  = 1'b0;
        aerr_d  = 1'b0;
        terr_d  = 1'b0;
        if (rd_q) begin
            ov_d  = 1'b1;
            od_d  = data_out;
            tmo_d = 8'd0;
            unique case (state_q)
                StHdr: begin
                    sof_d   = 1'b1;
                    len_d   = data_out[7:2];
                    par_d   = data_out;
                    aerr_d  = (data_out[1:0] != DEST_ADDR) || (data_out[1:0] == 2'b11);
                    state_d = (data_out[7:2] != 6'd0) ? StPay : StPar;
                end
                StPay: begin
                    par_d = par_q ^ data_out;
                    len_d = len_q - 6'd1;
                    if (len_q == 6'd1) begin
                        state_d = StPar;
                    end
                end
                StPar: begin
                    eof_d   = 1'b1;
                    perr_d  = (data_out != par_q);
                    cnt_d   = cnt_q + CNT_W'(1);
                    par_d   = 8'd0;
                    len_d   = 6'd0;
                    state_d = StHdr;
                end
                default: state_d = StHdr;
            endcase
        end else if ((state_q != StHdr) && !valid_out && sink_ready) begin
            // Starved mid-packet; a stall caused by our own sink does not count
            if (tmo_q == TmoLast) begin
                terr_d  = 1'b1;
                tmo_d   = 8'd0;
                par_d   = 8'd0;
                len_d   = 6'd0;
                state_d = StHdr;
            end else begin
                tmo_d = tmo_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StHdr;
            rd_q    <= 1'b0;
            len_q   <= 6'd0;
            par_q   <= 8'd0;
            tmo_q   <= 8'd0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= 8'd0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            perr_q  <= 1'b0;
            aerr_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            len_q   <= len_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            perr_q  <= perr_d;
            aerr_q  <= aerr_d;
            terr_q  <= terr_d;
        end
    end

    assign out_valid   = ov_q;
    assign out_data    = od_q;
    assign out_sof     = sof_q;
    assign out_eof     = eof_q;
    assign pkt_done    = eof_q;
    assign parity_err  = perr_q;
    assign addr_err    = aerr_q;
    assign timeout_err = terr_q;
    assign pkt_count   = cnt_q;

`ifdef ERR_CNT_EN
    logic [7:0] err_q, err_d;

    // Error pulses are mutually exclusive, so one increment per cycle suffices
    always_comb begin
        err_d = err_q;
        if ((perr_d || aerr_d || terr_d) && (err_q != 8'hff)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err_q <= 8'd0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`endif

endmodule
